// File: rtl/padder_pipe.sv
// padder_pipe: pipelined prefix adder/subtractor with valid/ready flow control.
// Define PADDER_PIPE_ZERO_DETECT_EN to build the registered zero flag.
module padder_pipe #(
  parameter int WIDTH  = 11,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  // Position 0 carries c0 (the G[-1] slot); position i+1 is operand bit i.
  localparam int N = WIDTH + 1;
  localparam int L = $clog2(N);

  function automatic logic [2*N-1:0] pg_lvl(
    input logic [N-1:0] g_i,
    input logic [N-1:0] p_i,
    input int           lo,
    input int           hi
  );
    logic [N-1:0] g, p, gn, pn;
    g = g_i;
    p = p_i;
    for (int l = 0; l < L; l++) begin
      if (l >= lo && l < hi) begin
        gn = g;
        pn = p;
        for (int i = 0; i < N; i++) begin
          if (i >= (1 << l)) begin
            gn[i] = g[i] | (p[i] & g[i-(1<<l)]);
            pn[i] = p[i] & p[i-(1<<l)];
          end
        end
        g = gn;
        p = pn;
      end
    end
    return {g, p};
  endfunction

  function automatic logic [N-1:0] g_lvl(
    input logic [N-1:0] g_i,
    input logic [N-1:0] p_i,
    input int           lo,
    input int           hi
  );
    logic [N-1:0] g, p, gn, pn;
    g = g_i;
    p = p_i;
    for (int l = 0; l < L; l++) begin
      if (l >= lo && l < hi) begin
        gn = g;
        pn = p;
        for (int i = 0; i < N; i++) begin
          if (i >= (1 << l)) begin
            gn[i] = g[i] | (p[i] & g[i-(1<<l)]);
            pn[i] = p[i] & p[i-(1<<l)];
          end
        end
        g = gn;
        p = pn;
      end
    end
    return g;
  endfunction

  logic [STAGES-1:0] r_v;
  logic [STAGES-1:0] w_ld;
  logic [STAGES-1:0] w_up;
  logic [STAGES-1:0] w_en;
  logic [WIDTH-1:0]  w_beff;

  logic [N-1:0]     w_g [STAGES];
  logic [N-1:0]     w_p [STAGES];
  logic [WIDTH-1:0] w_a [STAGES];
  logic [WIDTH-1:0] w_b [STAGES];

  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;

  assign w_beff = b ^ {WIDTH{sub}};

  assign w_g[0] = {a & w_beff, cin ^ sub};
  assign w_p[0] = {a | w_beff, 1'b0};
  assign w_a[0] = a;
  assign w_b[0] = w_beff;

  if (STAGES > 1) begin : g_up
    assign w_up = {r_v[STAGES-2:0], in_valid};
  end else begin : g_up1
    assign w_up = in_valid;
  end

  // A slice loads when empty or when its contents move on downstream.
  always_comb begin
    logic nx;
    nx = out_ready;
    w_ld = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_ld[k] = !r_v[k] || nx;
      nx = w_ld[k];
    end
  end

  assign w_en      = w_ld & w_up;
  assign in_ready  = w_ld[0];
  assign out_valid = r_v[STAGES-1];

  // Slice valid bits; bubbles are overwritten as they collapse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_ld[k]) r_v[k] <= w_up[k];
      end
    end
  end

`ifdef PADDER_PIPE_ZERO_DETECT_EN
  logic r_zero;
  assign zero = r_zero;
`else
  assign zero = 1'b0;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_sl
    localparam int LO = k * L / STAGES;
    localparam int HI = (k + 1) * L / STAGES;

    if (k < STAGES - 1) begin : g_mid
      logic [2*N-1:0]   w_pg;
      logic [N-1:0]     r_g;
      logic [N-1:0]     r_p;
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;

      assign w_pg = pg_lvl(w_g[k], w_p[k], LO, HI);

      // Partial prefix state and operands handed to the next slice.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_g <= '0;
          r_p <= '0;
          r_a <= '0;
          r_b <= '0;
        end else if (w_en[k]) begin
          r_g <= w_pg[2*N-1:N];
          r_p <= w_pg[N-1:0];
          r_a <= w_a[k];
          r_b <= w_b[k];
        end
      end

      assign w_g[k+1] = r_g;
      assign w_p[k+1] = r_p;
      assign w_a[k+1] = r_a;
      assign w_b[k+1] = r_b;
    end else begin : g_last
      logic [N-1:0]     w_c;
      logic [WIDTH-1:0] w_s;

      assign w_c = g_lvl(w_g[k], w_p[k], LO, HI);
      assign w_s = w_a[k] ^ w_b[k] ^ w_c[WIDTH-1:0];

      // Final sum and flags, held while the consumer stalls.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s    <= '0;
          r_cout <= 1'b0;
          r_ovf  <= 1'b0;
`ifdef PADDER_PIPE_ZERO_DETECT_EN
          r_zero <= 1'b0;
`endif
        end else if (w_en[k]) begin
          r_s    <= w_s;
          r_cout <= w_c[WIDTH];
          r_ovf  <= (w_a[k][WIDTH-1] == w_b[k][WIDTH-1]) &&
                    (w_s[WIDTH-1] != w_a[k][WIDTH-1]);
`ifdef PADDER_PIPE_ZERO_DETECT_EN
          r_zero <= ~|w_s;
`endif
        end
      end
    end
  end

  assign s    = r_s;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_padder_pipe.sv
// tb_padder_pipe: directed and random checks of padder_pipe
// against an arithmetic reference model.
module tb_padder_pipe;

  localparam int W = 11;
  localparam int S = 2;

`ifdef PADDER_PIPE_ZERO_DETECT_EN
  localparam bit ZE = 1'b1;
`else
  localparam bit ZE = 1'b0;
`endif

  typedef logic [63:0] u64;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    logic         z;
    bit           lit;
    logic [W-1:0] ls;
    logic         lc;
    logic         lo;
    int           acc;
    bit           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;
  logic         zero;

  padder_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int to_cnt = 0;
  int to_seen = 0;

  bit           lit_en = 1'b0;
  logic [W-1:0] lit_s = '0;
  logic         lit_c = 1'b0;
  logic         lit_o = 1'b0;
  bit           lat_en = 1'b0;

  bit           held = 1'b0;
  logic [W-1:0] h_s;
  logic         h_c, h_o, h_z;

  // Reference: plain unsigned/signed arithmetic on the operands.
  function automatic exp_t model(logic [W-1:0] av, logic [W-1:0] bv,
                                 logic sb, logic ci);
    exp_t   e = '{default: '0};
    longint ua = longint'(av);
    longint ub = longint'(bv);
    longint c  = ci ? 64'sd1 : 64'sd0;
    longint half = longint'(1) << (W - 1);
    longint full = half * 2;
    longint r, sa, sv, sr;
    if (!sb) begin
      r = ua + ub + c;
      e.c = (r >= full);
    end else begin
      r = ua - ub - c;
      e.c = (r >= 0);
    end
    e.s = r[W-1:0];
    sa = (ua >= half) ? ua - full : ua;
    sv = (ub >= half) ? ub - full : ub;
    sr = sb ? sa - sv - c : sa + sv + c;
    e.o = (sr > half - 1) || (sr < -half);
    e.z = ZE ? (e.s == '0) : 1'b0;
    return e;
  endfunction

  task automatic chk(input string nm, input u64 act, input u64 exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  // Compare process: samples on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      q.delete();
      held = 1'b0;
      chk("rst_out_valid", u64'(out_valid), u64'(0));
      chk("rst_in_ready", u64'(in_ready), u64'(1));
      chk("rst_outputs", u64'({s, cout, ovf, zero}), u64'(0));
    end else begin
      if (to_cnt != to_seen) begin
        chk("drain_bound", u64'(to_cnt - to_seen), u64'(0));
        to_seen = to_cnt;
      end
      chk("in_ready", u64'(in_ready),
          u64'((q.size() < S) || out_ready));
      if (q.size() == 0)
        chk("idle_out_valid", u64'(out_valid), u64'(0));
      if (held) begin
        chk("stall_valid", u64'(out_valid), u64'(1));
        chk("stall_hold", u64'({s, cout, ovf, zero}),
            u64'({h_s, h_c, h_o, h_z}));
      end
      if (out_valid && !out_ready) begin
        held = 1'b1;
        h_s = s; h_c = cout; h_o = ovf; h_z = zero;
      end else begin
        held = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("beat_expected", u64'(q.size()), u64'(1));
        end else begin
          e = q.pop_front();
          chk("result", u64'({s, cout, ovf, zero}),
              u64'({e.s, e.c, e.o, e.z}));
          if (e.lit)
            chk("literal", u64'({s, cout, ovf, zero}),
                u64'({e.ls, e.lc, e.lo, ZE ? (e.ls == '0) : 1'b0}));
          if (e.lat)
            chk("latency", u64'(cyc - e.acc), u64'(S));
        end
      end
      if (in_valid && in_ready) begin
        e = model(a, b, sub, cin);
        e.lit = lit_en;
        e.ls = lit_s;
        e.lc = lit_c;
        e.lo = lit_o;
        e.acc = cyc;
        e.lat = lat_en;
        q.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [W-1:0] av, input logic [W-1:0] bv,
                     input logic sb, input logic ci,
                     input logic [W-1:0] ls, input logic lc,
                     input logic lo);
    in_valid = 1'b1;
    a = av; b = bv; sub = sb; cin = ci;
    lit_en = 1'b1; lit_s = ls; lit_c = lc; lit_o = lo;
    tick();
    in_valid = 1'b0;
    lit_en = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ba[8];
    logic [W-1:0] bb[8];
    logic         bs[8];
    logic         bc[8];
    int sent, t;
    bit acc;

    rst_n = 1'b1;
    in_valid = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Directed vectors with hand-computed results.
    lat_en = 1'b1;
    drv(11'h7FF, 11'h001, 1'b0, 1'b0, 11'h000, 1'b1, 1'b0);
    drv(11'h000, 11'h001, 1'b1, 1'b0, 11'h7FF, 1'b0, 1'b0);
    drv(11'h3FF, 11'h001, 1'b0, 1'b0, 11'h400, 1'b0, 1'b1);
    drv(11'h400, 11'h001, 1'b1, 1'b0, 11'h3FF, 1'b1, 1'b1);
    drv(11'h005, 11'h003, 1'b1, 1'b1, 11'h001, 1'b1, 1'b0);
    drv(11'h2AA, 11'h155, 1'b0, 1'b1, 11'h400, 1'b0, 1'b1);
    drv(11'h123, 11'h123, 1'b1, 1'b0, 11'h000, 1'b1, 1'b0);
    repeat (S + 2) tick();
    lat_en = 1'b0;

    // Backpressure: out_ready cycles 1,0,0,1.
    for (int i = 0; i < 8; i++) begin
      ba[i] = W'($urandom);
      bb[i] = W'($urandom);
      bs[i] = 1'($urandom);
      bc[i] = 1'($urandom);
    end
    sent = 0;
    t = 0;
    while ((sent < 8 || q.size() != 0) && t < 200) begin
      out_ready = (t % 4 == 0) || (t % 4 == 3);
      in_valid = (sent < 8);
      if (sent < 8) begin
        a = ba[sent]; b = bb[sent]; sub = bs[sent]; cin = bc[sent];
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      if (acc) sent++;
      t++;
    end
    if (t >= 200) to_cnt++;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();

    // Reset with two beats held in the pipe.
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 11'h0F0; b = 11'h00F; sub = 1'b0; cin = 1'b0;
    tick();
    a = 11'h001; b = 11'h002; sub = 1'b1;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) tick();

    // Full throughput: one beat per cycle, no stalls.
    lat_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      in_valid = 1'b1;
      a = W'($urandom); b = W'($urandom);
      sub = 1'($urandom); cin = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    repeat (S + 2) tick();
    lat_en = 1'b0;

    // Random valid and ready.
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'($urandom);
      out_ready = ($urandom % 4) != 0;
      a = W'($urandom); b = W'($urandom);
      sub = 1'($urandom); cin = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    t = 0;
    while (q.size() != 0 && t < 50) begin
      tick();
      t++;
    end
    if (q.size() != 0) to_cnt++;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
